// File: rtl/dcr_bus_bridge_pkg.sv
// Shared definitions for the SATA port DCR bridge: FSM encoding and local
// register offsets of the port register block.
package dcr_bus_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WSTROBE = 3'd1,
        RWAIT   = 3'd2,
        ACK     = 3'd3,
        HOLD    = 3'd4
    } bridge_state_t;

    localparam logic [5:0] OFS_STATUS   = 6'h00;
    localparam logic [5:0] OFS_DMA_CTRL = 6'h04;
    localparam logic [5:0] OFS_DMA_ADDR = 6'h08;

endpackage

// File: rtl/dcr_bus_bridge.sv
// Turns each selected DCR transfer into exactly one local register access,
// then acknowledges until the master drops its request.
//
// state   | meaning
// IDLE    | waiting for a selected, unambiguous read or write request
// WSTROBE | local write strobe asserted for this single cycle
// RWAIT   | counting down the local read latency
// ACK     | acknowledge (and read data) presented to the DCR master
// HOLD    | acknowledge held until the originating request drops
module dcr_bus_bridge
    import dcr_bus_bridge_pkg::*;
#(
    parameter logic [9:0]  C_DCR_BASEADDR = 10'h000,
    parameter int unsigned C_READ_LATENCY = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [9:0]  DCR_ABus,
    input  logic        DCR_Read,
    input  logic        DCR_Write,
    input  logic [31:0] DCR_DBus,
    output logic        Sl_dcrAck,
    output logic [31:0] Sl_dcrDBus,
    output logic [5:0]  address,
    output logic        write,
    output logic [31:0] writedata,
    input  logic [31:0] readdata
);

    localparam logic [2:0] LAT = 3'(C_READ_LATENCY);

    bridge_state_t state, next_state;
    logic [2:0]    cnt;
    logic          is_read;
    logic          sel;
    logic          req_live;
    logic          launch_wr;
    logic          launch_rd;

    assign sel      = (DCR_ABus[9:4] == C_DCR_BASEADDR[9:4]);
    assign req_live = is_read ? DCR_Read : DCR_Write;

    always_comb begin
        next_state = state;
        launch_wr  = 1'b0;
        launch_rd  = 1'b0;
        case (state)
            IDLE: begin
                // Read and write together is a protocol violation: ignored.
                if (sel && DCR_Write && !DCR_Read) begin
                    launch_wr  = 1'b1;
                    next_state = WSTROBE;
                end else if (sel && DCR_Read && !DCR_Write) begin
                    launch_rd  = 1'b1;
                    next_state = RWAIT;
                end
            end
            WSTROBE: next_state = ACK;
            RWAIT:   if (cnt == 3'd0) next_state = ACK;
            ACK:     next_state = req_live ? HOLD : IDLE;
            HOLD:    if (!req_live) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            is_read    <= 1'b0;
            address    <= 6'h00;
            writedata  <= 32'h0;
            write      <= 1'b0;
            Sl_dcrAck  <= 1'b0;
            Sl_dcrDBus <= 32'h0;
        end else begin
            state     <= next_state;
            write     <= (next_state == WSTROBE);
            Sl_dcrAck <= (next_state == ACK) || (next_state == HOLD);

            if (launch_wr) begin
                address   <= {DCR_ABus[3:0], 2'b00};
                writedata <= DCR_DBus;
                is_read   <= 1'b0;
            end else if (launch_rd) begin
                address <= {DCR_ABus[3:0], 2'b00};
                is_read <= 1'b1;
            end

            if (launch_rd)
                cnt <= LAT;
            else if (state == RWAIT && cnt != 3'd0)
                cnt <= cnt - 3'd1;

            // Data is non-zero only while acknowledging a read.
            if (state == RWAIT && cnt == 3'd0)
                Sl_dcrDBus <= readdata;
            else if (next_state == IDLE)
                Sl_dcrDBus <= 32'h0;
        end
    end

endmodule
